// File: rtl/rr_channel_logger_pkg.sv
// Shared types for the rr channel logger: log record, logging-bus
// producer bundle and logger FSM states.
package rr_channel_logger_pkg;

   localparam int RR_CHANNEL_WIDTH_BITS = 32;

   typedef struct packed {
      logic                             b;
      logic                             e;
      logic [RR_CHANNEL_WIDTH_BITS-1:0] data;
   } log_rec_t;

   typedef struct packed {
      logic                             logb_valid;
      logic                             loge_valid;
      logic [RR_CHANNEL_WIDTH_BITS-1:0] logb_data;
   } rr_logging_bus_t;

   typedef enum logic {
      ST_IDLE,
      ST_ACTIVE
   } log_state_t;

endpackage

// File: rtl/rr_log_fifo.sv
// Synchronous log-record FIFO with registered storage and an
// occupancy count; full is judged on the pre-pop count.
import rr_channel_logger_pkg::*;

module rr_log_fifo #(
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  log_rec_t      wdata,
   input  logic          pop,
   output log_rec_t      rdata,
   output logic          empty,
   output logic [CW-1:0] count
);

   log_rec_t      mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] cnt;
   logic          full;
   logic          do_push;
   logic          do_pop;

   assign full    = (cnt == CW'(DEPTH));
   assign empty   = (cnt == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rdata   = mem[rd_ptr];
   assign count   = cnt;

   // pointer and occupancy bookkeeping, pointers wrap naturally
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         cnt <= cnt + CW'(do_push) - CW'(do_pop);
      end
   end

   // record storage, visible at the head one cycle after the write
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/rr_channel_logger.sv
// Pass-through channel monitor that logs begin/end events of each
// transfer; RR_LOGGER_STALL_CNT_EN adds a saturating stall counter.
import rr_channel_logger_pkg::*;

module rr_channel_logger #(
   parameter int DATA_WIDTH     = 32,
   parameter int LOG_FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  log_logb_valid,
   output logic                  log_loge_valid,
   output logic [DATA_WIDTH-1:0] log_logb_data,
   input  logic                  log_ready,
   output logic                  protocol_err
`ifdef RR_LOGGER_STALL_CNT_EN
   ,
   output logic [31:0]           stall_cnt
`endif
);

   localparam int CW = $clog2(LOG_FIFO_DEPTH) + 1;

   log_state_t      state;
   log_rec_t        push_rec;
   log_rec_t        head;
   rr_logging_bus_t bus;
   logic [CW-1:0]   count;
   logic            empty;
   logic            gate_open;
   logic            fire;
   logic            push;
   logic            pop;

   assign gate_open = (count < CW'(LOG_FIFO_DEPTH));
   assign out_data  = in_data;
   assign out_valid = in_valid & gate_open;
   assign in_ready  = out_ready & gate_open;
   assign fire      = out_valid & out_ready;
   assign pop       = ~empty & log_ready;

   // choose which event record, if any, enters the log this cycle
   always_comb begin
      push     = 1'b0;
      push_rec = '0;
      unique case (state)
         ST_IDLE: begin
            if (in_valid && gate_open) begin
               push          = 1'b1;
               push_rec.b    = 1'b1;
               push_rec.e    = fire;
               push_rec.data = RR_CHANNEL_WIDTH_BITS'(in_data);
            end
         end
         ST_ACTIVE: begin
            if (fire) begin
               push       = 1'b1;
               push_rec.e = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // transaction tracker with sticky protocol error
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_IDLE;
         protocol_err <= 1'b0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (in_valid && gate_open && !fire) state <= ST_ACTIVE;
            end
            ST_ACTIVE: begin
               if (fire) begin
                  state <= ST_IDLE;
               end else if (!in_valid) begin
                  protocol_err <= 1'b1;
                  state        <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   rr_log_fifo #(
      .DEPTH (LOG_FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .wdata (push_rec),
      .pop   (pop),
      .rdata (head),
      .empty (empty),
      .count (count)
   );

   assign bus.logb_valid = ~empty & head.b;
   assign bus.loge_valid = ~empty & head.e;
   assign bus.logb_data  = head.data;

   assign log_logb_valid = bus.logb_valid;
   assign log_loge_valid = bus.loge_valid;
   assign log_logb_data  = bus.logb_data[DATA_WIDTH-1:0];

`ifdef RR_LOGGER_STALL_CNT_EN
   // count cycles where upstream is held off by a full log
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (in_valid && !gate_open && stall_cnt != '1) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_rr_channel_logger.sv
// Scoreboard bench for rr_channel_logger; stall counter checks are
// compiled in when RR_LOGGER_STALL_CNT_EN is defined.
module tb_rr_channel_logger;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        log_logb_valid;
   logic        log_loge_valid;
   logic [31:0] log_logb_data;
   logic        log_ready;
   logic        protocol_err;
`ifdef RR_LOGGER_STALL_CNT_EN
   logic [31:0] stall_cnt;
`endif

   typedef struct {
      logic        b;
      logic        e;
      logic [31:0] d;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   n_beg   = 0;
   int   n_end   = 0;
   int   fires;
   logic [31:0] seq;

   always #5 clk = ~clk;

   rr_channel_logger #(
      .DATA_WIDTH     (32),
      .LOG_FIFO_DEPTH (4)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_data        (in_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_data       (out_data),
      .log_logb_valid (log_logb_valid),
      .log_loge_valid (log_loge_valid),
      .log_logb_data  (log_logb_data),
      .log_ready      (log_ready),
      .protocol_err   (protocol_err)
`ifdef RR_LOGGER_STALL_CNT_EN
      ,
      .stall_cnt      (stall_cnt)
`endif
   );

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h", name, act, req);
      end
   endtask

   task automatic expect_rec(input logic b, input logic e,
                             input logic [31:0] d);
      exp_t x;
      x.b = b;
      x.e = e;
      x.d = d;
      exp_q.push_back(x);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 60 && exp_q.size() != 0; i++) cyc();
      check(name, 64'(exp_q.size()), 64'd0);
   endtask

   // monitor: every accepted head record is matched against the queue
   always @(negedge clk) begin
      if (!rst && (log_logb_valid || log_loge_valid) && log_ready) begin
         if (log_logb_valid) n_beg++;
         if (log_loge_valid) n_end++;
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_record: got b=%0b e=%0b d=%0h, want none",
                     log_logb_valid, log_loge_valid, log_logb_data);
         end else begin
            mon_e = exp_q.pop_front();
            check("record",
                  {30'd0, log_logb_valid, log_loge_valid, log_logb_data},
                  {30'd0, mon_e.b, mon_e.e, mon_e.d});
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got no finish, want finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      log_ready = 1'b1;
      repeat (2) cyc();
      rst = 1'b0;

      // reset state
      @(negedge clk);
      check("rst_logb", 64'(log_logb_valid), 64'd0);
      check("rst_loge", 64'(log_loge_valid), 64'd0);
      check("rst_err", 64'(protocol_err), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
`ifdef RR_LOGGER_STALL_CNT_EN
      check("rst_stall", 64'(stall_cnt), 64'd0);
`endif
      cyc();

      // single-cycle transfer logs one begin+end record
      in_valid = 1'b1;
      in_data  = 32'hA5A5A5A5;
      expect_rec(1'b1, 1'b1, 32'hA5A5A5A5);
      @(negedge clk);
      check("pulse_out_valid", 64'(out_valid), 64'd1);
      check("pulse_out_data", 64'(out_data), 64'hA5A5A5A5);
      check("pulse_logb_early", 64'(log_logb_valid), 64'd0);
      cyc();
      in_valid = 1'b0;
      @(negedge clk);
      check("pulse_logb_next", 64'(log_logb_valid), 64'd1);
      drain("drain_pulse");

      // stretched transfer: begin captured on cycle 0, end on fire
      in_valid  = 1'b1;
      in_data   = 32'h12345678;
      out_ready = 1'b0;
      expect_rec(1'b1, 1'b0, 32'h12345678);
      cyc();
      in_data = 32'hDEAD0000;
      repeat (2) cyc();
      out_ready = 1'b1;
      expect_rec(1'b0, 1'b1, 32'h0);
      cyc();
      in_valid = 1'b0;
      drain("drain_stretch");
      repeat (3) cyc();
      @(negedge clk);
      check("stretch_no_extra", 64'(log_logb_valid | log_loge_valid), 64'd0);

      // full log stalls the channel, no event lost
      log_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_data  = 32'(i + 1);
         expect_rec(1'b1, 1'b1, 32'(i + 1));
         cyc();
      end
      in_data = 32'd5;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("full_in_ready", 64'(in_ready), 64'd0);
         check("full_out_valid", 64'(out_valid), 64'd0);
         cyc();
      end
      log_ready = 1'b1;
      @(negedge clk);
      check("full_prepop_ready", 64'(in_ready), 64'd0);
`ifdef RR_LOGGER_STALL_CNT_EN
      check("stall_cnt_3", 64'(stall_cnt), 64'd3);
`endif
      cyc();
      @(negedge clk);
      check("after_pop_ready", 64'(in_ready), 64'd1);
      expect_rec(1'b1, 1'b1, 32'd5);
      cyc();
      in_valid = 1'b0;
      @(negedge clk);
`ifdef RR_LOGGER_STALL_CNT_EN
      check("stall_cnt_4", 64'(stall_cnt), 64'd4);
`endif
      drain("drain_full");

      // valid dropped mid-transaction raises sticky error
      in_valid  = 1'b1;
      in_data   = 32'h0BAD0001;
      out_ready = 1'b0;
      expect_rec(1'b1, 1'b0, 32'h0BAD0001);
      @(negedge clk);
      check("err_before", 64'(protocol_err), 64'd0);
      cyc();
      in_valid = 1'b0;
      @(negedge clk);
      check("err_same_cycle", 64'(protocol_err), 64'd0);
      cyc();
      @(negedge clk);
      check("err_set", 64'(protocol_err), 64'd1);
      cyc();
      in_valid  = 1'b1;
      in_data   = 32'h600D0002;
      out_ready = 1'b1;
      expect_rec(1'b1, 1'b1, 32'h600D0002);
      cyc();
      in_valid = 1'b0;
      repeat (3) cyc();
      @(negedge clk);
      check("err_sticky", 64'(protocol_err), 64'd1);
      drain("drain_err");

      // reset with three records queued and a begin outstanding
      log_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'h11;
      cyc();
      in_data = 32'h22;
      cyc();
      in_data   = 32'h33;
      out_ready = 1'b0;
      cyc();
      @(negedge clk);
      check("pre_rst_logb", 64'(log_logb_valid), 64'd1);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_logb", 64'(log_logb_valid), 64'd0);
      check("async_rst_loge", 64'(log_loge_valid), 64'd0);
      check("async_rst_err", 64'(protocol_err), 64'd0);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      cyc();
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_ready", 64'(in_ready), 64'd1);
      check("post_rst_logb", 64'(log_logb_valid), 64'd0);
      cyc();
      log_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 32'h44;
      expect_rec(1'b1, 1'b1, 32'h44);
      cyc();
      in_valid = 1'b0;
      drain("drain_rst");

      // continuous traffic with log_ready toggling
      n_beg = 0;
      n_end = 0;
      fires = 0;
      seq   = 32'h1000;
      for (int c = 0; c < 1000; c++) begin
         log_ready = 1'((c & 1) == 0);
         in_valid  = 1'b1;
         in_data   = seq;
         @(negedge clk);
         if (in_ready) begin
            expect_rec(1'b1, 1'b1, seq);
            fires++;
            seq++;
         end
         cyc();
      end
      in_valid  = 1'b0;
      log_ready = 1'b1;
      drain("drain_stream");
      check("stream_begins", 64'(n_beg), 64'(fires));
      check("stream_ends", 64'(n_end), 64'(fires));
      check("stream_rate", 64'(fires >= 480 && fires <= 520), 64'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
